// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit. It owns HI/LO and runs mult/multu/div/divu with a fixed busy latency.
// It also provides mfhi/mflo read data and handles single-cycle mthi/mtlo writes.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  MDUOp,
  input  logic        MDUStart,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] Out,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [0:0]  o_dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_cnt;
  logic [63:0] r_res;
  logic        r_nowrite;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_start;
  logic        w_is_div;
  logic        w_sdiv;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [63:0] w_res;

  assign w_start  = MDUStart && !Req && (MDUOp < 5'd4) && (r_state == S_IDLE);
  assign w_is_div = (MDUOp == 5'd2) || (MDUOp == 5'd3);
  assign w_sdiv   = (MDUOp == 5'd2);

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide works on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0 naturally.
  assign w_a_mag  = (w_sdiv && A[31]) ? (32'd0 - A) : A;
  assign w_b_mag  = (w_sdiv && B[31]) ? (32'd0 - B) : B;
  assign w_b_safe = (B == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_q      = (w_sdiv && (A[31] ^ B[31])) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r      = (w_sdiv && A[31]) ? (32'd0 - w_r_mag) : w_r_mag;

  always_comb begin
    w_res = 64'd0;
    case (MDUOp)
      5'd0:    w_res = w_prod_s;
      5'd1:    w_res = w_prod_u;
      5'd2,
      5'd3:    w_res = {w_r, w_q};
      default: w_res = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 32'd0;
      r_res     <= 64'd0;
      r_nowrite <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_RUN;
            r_res     <= w_res;
            r_nowrite <= w_is_div && (B == 32'd0);
            r_cnt     <= w_is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
          end else if (!Req && (MDUOp == 5'd6)) begin
            r_hi <= A;
          end else if (!Req && (MDUOp == 5'd7)) begin
            r_lo <= A;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 32'd1;
          if (r_cnt == 32'd1) begin
            r_state <= S_IDLE;
            if (!r_nowrite) begin
              r_hi <= r_res[63:32];
              r_lo <= r_res[31:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy        = (r_state == S_RUN);
  assign HI          = r_hi;
  assign LO          = r_lo;
  assign o_dbg_state = r_state;
  assign Out         = (MDUOp == 5'd4) ? r_hi : ((MDUOp == 5'd5) ? r_lo : 32'd0);

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: a {HI,LO} scoreboard is filled at launch and drained when Busy drops.
module tb_mdu_unit;
  logic        clk;
  logic        reset;
  logic [4:0]  MDUOp;
  logic        MDUStart;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Busy;
  logic [31:0] Out;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [0:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .MDUStart(MDUStart),
    .A(A), .B(B), .Req(Req), .Busy(Busy), .Out(Out), .HI(HI), .LO(LO),
    .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model uses 64-bit arithmetic, independent of the magnitude-based divider.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = {m_hi, m_lo};
    case (op)
      5'd0: res = 64'(sa * sb);
      5'd1: res = {32'd0, a} * {32'd0, b};
      5'd2: if (b != 32'd0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      5'd3: if (b != 32'd0) res = {a % b, a / b};
      default: res = {m_hi, m_lo};
    endcase
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch an op; optionally inject a start/op/Req during busy cycle inj_cyc.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic req, input int inj_cyc, input logic [4:0] inj_op, input logic inj_req);
    int n;
    int exp_n;
    logic [63:0] e;
    MDUOp = op; A = a; B = b; MDUStart = 1'b1; Req = req;
    if (!req && op <= 5'd3) exp_q.push_back(model(op, a, b));
    step();
    MDUStart = 1'b0; Req = 1'b0; MDUOp = 5'd31;
    if (req || op > 5'd3) begin
      check("no_launch_busy", {63'd0, Busy}, 64'd0);
      check("no_launch_hilo", {HI, LO}, {m_hi, m_lo});
    end else begin
      exp_n = (op < 5'd2) ? 5 : 10;
      n = 0;
      while (Busy && n < 200) begin
        n++;
        if (n == inj_cyc) begin
          MDUOp = inj_op; A = 32'hDEADBEEF; MDUStart = 1'b1; Req = inj_req;
        end else begin
          MDUOp = 5'd31; MDUStart = 1'b0; Req = 1'b0;
        end
        step();
      end
      MDUOp = 5'd31; MDUStart = 1'b0; Req = 1'b0;
      check("busy_len", 64'(n), 64'(exp_n));
      if (exp_q.size() == 0) begin
        check("sb_empty", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("hi", {32'd0, HI}, {32'd0, e[63:32]});
        check("lo", {32'd0, LO}, {32'd0, e[31:0]});
        m_hi = e[63:32];
        m_lo = e[31:0];
      end
    end
  endtask

  task automatic do_mt(input logic [4:0] op, input logic [31:0] a);
    MDUOp = op; A = a; MDUStart = 1'($urandom_range(0, 1)); Req = 1'b0;
    step();
    check("mt_busy", {63'd0, Busy}, 64'd0);
    if (op == 5'd6) m_hi = a; else m_lo = a;
    MDUOp = 5'd31; MDUStart = 1'b0;
    check("mt_hilo", {HI, LO}, {m_hi, m_lo});
  endtask

  initial begin
    logic [4:0] rop;
    logic [31:0] ra, rb;
    reset = 1'b0; MDUOp = 5'd31; MDUStart = 1'b0; A = 32'd0; B = 32'd0; Req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    check("rst_state", {63'd0, dbg_state}, 64'd0);
    reset = 1'b1;
    step();

    // mthi / mfhi / mflo / out default
    do_mt(5'd6, 32'hABCD1234);
    check("mthi_val", {32'd0, HI}, 64'h0000_0000_ABCD_1234);
    MDUOp = 5'd4; #1;
    check("mfhi_out", {32'd0, Out}, 64'h0000_0000_ABCD_1234);
    do_mt(5'd7, 32'h00005555);
    MDUOp = 5'd5; #1;
    check("mflo_out", {32'd0, Out}, 64'h0000_0000_0000_5555);
    MDUOp = 5'd0; #1;
    check("out_zero", {32'd0, Out}, 64'd0);

    // reset mid-run discards the in-flight mult and clears HI/LO
    MDUOp = 5'd0; A = 32'd3; B = 32'd5; MDUStart = 1'b1;
    step();
    MDUStart = 1'b0; MDUOp = 5'd31;
    check("run_busy", {63'd0, Busy}, 64'd1);
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("midrst_busy", {63'd0, Busy}, 64'd0);
    check("midrst_hilo", {HI, LO}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    step();
    reset = 1'b1;
    step();

    do_op(5'd0, 32'd7, 32'd6, 1'b0, 0, 5'd31, 1'b0);
    check("mult_42", {HI, LO}, 64'd42);
    do_op(5'd0, 32'hFFFFFFFF, 32'd2, 1'b0, 0, 5'd31, 1'b0);
    check("mult_neg", {HI, LO}, 64'hFFFFFFFF_FFFFFFFE);
    do_op(5'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 0, 5'd31, 1'b0);
    check("multu", {HI, LO}, 64'h00000001_FFFFFFFE);
    do_op(5'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 5'd31, 1'b0);
    check("div_neg", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(5'd3, 32'd7, 32'd2, 1'b0, 0, 5'd31, 1'b0);
    check("divu", {HI, LO}, 64'h00000001_00000003);
    do_op(5'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 5'd31, 1'b0);
    check("div_ovf", {HI, LO}, 64'h00000000_80000000);

    // divide by zero keeps HI/LO
    do_mt(5'd6, 32'h11);
    do_mt(5'd7, 32'h22);
    do_op(5'd3, 32'd99, 32'd0, 1'b0, 0, 5'd31, 1'b0);
    check("div0", {HI, LO}, 64'h00000011_00000022);
    do_op(5'd2, 32'd99, 32'd0, 1'b0, 0, 5'd31, 1'b0);

    // Req suppresses a start; Req during run is ignored
    do_op(5'd1, 32'd9, 32'd9, 1'b1, 0, 5'd31, 1'b0);
    do_op(5'd2, 32'd100, 32'd7, 1'b0, 4, 5'd31, 1'b1);
    // start while busy is ignored, mtlo while busy is ignored
    do_op(5'd0, 32'd1000, 32'd3, 1'b0, 2, 5'd1, 1'b0);
    do_op(5'd0, 32'd12, 32'd12, 1'b0, 2, 5'd7, 1'b0);
    check("mtlo_busy", {32'd0, LO}, 64'd144);
    // mfhi op with start does not launch
    do_op(5'd4, 32'd1, 32'd1, 1'b0, 0, 5'd31, 1'b0);

    for (int i = 0; i < 16; i++) begin
      rop = 5'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      do_op(rop, ra, rb, 1'b0, 0, 5'd31, 1'b0);
    end

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
